alu_issue_stage: RTL and testbench

//   Decode/operand-fetch/writeback stage directly upstream of the 16-bit ALU. Accepts 16-bit

---
 rtl/alu_issue_stage_pkg.sv | 55 +++++
 rtl/alu_issue_stage_if.sv | 26 ++
 rtl/alu_issue_stage_regfile.sv | 42 ++++
 rtl/alu_issue_stage.sv | 130 +++++++++++++
 tb/tb_alu_issue_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and types for the ALU issue stage: widths, opcodes, FSM states and
// instruction field layout.
package alu_pkg;

  localparam int unsigned NUM_BITS = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned OP_SIZE  = 4;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);
  localparam int unsigned INSTR_W  = 16;

  localparam logic [OP_SIZE-1:0] OP_ADD = 4'h0;
  localparam logic [OP_SIZE-1:0] OP_SUB = 4'h1;
  localparam logic [OP_SIZE-1:0] OP_MUL = 4'h2;
  localparam logic [OP_SIZE-1:0] OP_AND = 4'h3;
  localparam logic [OP_SIZE-1:0] OP_DIV = 4'h4;
  localparam logic [OP_SIZE-1:0] OP_MOD = 4'h5;
  localparam logic [OP_SIZE-1:0] OP_OR  = 4'h6;
  localparam logic [OP_SIZE-1:0] OP_LE  = 4'h7;
  localparam logic [OP_SIZE-1:0] OP_LDI = 4'h8;
  localparam logic [OP_SIZE-1:0] OP_NOP = 4'hF;

  // Field LSB positions inside the instruction word.
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_SIZE-1:0] opcode;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  rs1;
    logic [REG_AW-1:0]  rs2;
  } instr_t;

  function automatic instr_t decode_instr(logic [INSTR_W-1:0] word);
    instr_t f;
    f.opcode = word[OPC_LSB +: OP_SIZE];
    f.rd     = word[RD_LSB  +: REG_AW];
    f.rs1    = word[RS1_LSB +: REG_AW];
    f.rs2    = word[RS2_LSB +: REG_AW];
    return f;
  endfunction

  // Opcodes above LDI retire without a writeback.
  function automatic logic is_nop(logic [OP_SIZE-1:0] opcode);
    return opcode > OP_LDI;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake, ALU operand/result bus and writeback report of the issue stage.
interface alu_issue_if;
  import alu_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_W-1:0]   instr;
  logic [OP_SIZE-1:0]   alu_operator;
  logic [NUM_BITS-1:0]  alu_op1;
  logic [NUM_BITS-1:0]  alu_op2;
  logic [NUM_BITS-1:0]  alu_out;
  logic                 wb_valid;
  logic [REG_AW-1:0]    wb_addr;
  logic [NUM_BITS-1:0]  wb_data;

  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, alu_operator, alu_op1, alu_op2, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, alu_operator, alu_op1, alu_op2, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/alu_issue_stage_regfile.sv
// Register file for the issue stage: two operand read ports, one debug read port and one
// synchronous write port. r0 reads as zero and ignores writes.
module issue_regfile #(
  parameter int unsigned NumRegs = 16,
  parameter int unsigned NumBits = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [$clog2(NumRegs)-1:0] raddr_a_i,
  output logic [NumBits-1:0]         rdata_a_o,
  input  logic [$clog2(NumRegs)-1:0] raddr_b_i,
  output logic [NumBits-1:0]         rdata_b_o,
  input  logic [$clog2(NumRegs)-1:0] dbg_addr_i,
  output logic [NumBits-1:0]         dbg_data_o,
  input  logic                       we_i,
  input  logic [$clog2(NumRegs)-1:0] waddr_i,
  input  logic [NumBits-1:0]         wdata_i
);

  logic [NumBits-1:0] mem_q [NumRegs];
  logic [NumBits-1:0] mem_d [NumRegs];

  always_comb begin
    mem_d = mem_q;
    if (we_i && (waddr_i != '0)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode / operand-fetch / writeback stage in front of the 16-bit ALU, one instruction in flight.
// Optional DIV_ZERO_TRAP_EN: DIV/MOD by zero skips the write and pulses div_zero instead.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  alu_issue_if.slave          bus,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [NUM_BITS-1:0] dbg_data
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic                div_zero
`endif
);

  state_e state_q, state_d;

  logic [OP_SIZE-1:0]  opcode_q, opcode_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [7:0]          imm_q, imm_d;
  logic [NUM_BITS-1:0] op1_q, op1_d;
  logic [NUM_BITS-1:0] op2_q, op2_d;
  logic [NUM_BITS-1:0] result_q, result_d;
  logic                trap_q, trap_d;

  instr_t              instr_f;
  logic [NUM_BITS-1:0] rs1_data;
  logic [NUM_BITS-1:0] rs2_data;
  logic                wb_we;

  assign instr_f = decode_instr(bus.instr);

  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    rd_d             = rd_q;
    imm_d            = imm_q;
    op1_d            = op1_q;
    op2_d            = op2_q;
    result_d         = result_q;
    trap_d           = trap_q;
    bus.instr_ready  = 1'b0;
    bus.alu_operator = OP_NOP;
    bus.wb_valid     = 1'b0;
    bus.wb_addr      = '0;
    bus.wb_data      = '0;
    wb_we            = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          opcode_d = instr_f.opcode;
          rd_d     = instr_f.rd;
          imm_d    = {instr_f.rs1, instr_f.rs2};
          op1_d    = rs1_data;
          op2_d    = rs2_data;
          state_d  = StExec;
        end
      end
      StExec: begin
        bus.alu_operator = opcode_q;
        result_d = (opcode_q == OP_LDI) ? {8'h00, imm_q} : bus.alu_out;
`ifdef DIV_ZERO_TRAP_EN
        trap_d = ((opcode_q == OP_DIV) || (opcode_q == OP_MOD)) && (op2_q == '0);
`else
        trap_d = 1'b0;
`endif
        state_d = is_nop(opcode_q) ? StIdle : StWb;
      end
      StWb: begin
        // A trapped instruction still spends its WB cycle, but reports nothing.
        wb_we        = !trap_q;
        bus.wb_valid = !trap_q;
        bus.wb_addr  = rd_q;
        bus.wb_data  = result_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      trap_q   <= trap_d;
    end
  end

  assign bus.alu_op1 = op1_q;
  assign bus.alu_op2 = op2_q;

`ifdef DIV_ZERO_TRAP_EN
  assign div_zero = (state_q == StWb) && trap_q;
`endif

  issue_regfile #(
    .NumRegs (NUM_REGS),
    .NumBits (NUM_BITS)
  ) u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst),
    .raddr_a_i  (instr_f.rs1),
    .rdata_a_o  (rs1_data),
    .raddr_b_i  (instr_f.rs2),
    .rdata_b_o  (rs2_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (wb_we),
    .waddr_i    (rd_q),
    .wdata_i    (result_q)
  );

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal checks followed by randomized traffic compared
// every cycle against a transaction-level model of the stage.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero;
`endif

  alu_issue_if bus ();

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`ifdef DIV_ZERO_TRAP_EN
    ,
    .div_zero (div_zero)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference ALU: drives the DUT's alu_out and also predicts results for the model.
  function automatic logic [15:0] alu_f(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return a & b;
      4'h4: return (b == 16'h0) ? 16'hFFFF : a / b;
      4'h5: return (b == 16'h0) ? a : a % b;
      4'h6: return a | b;
      4'h7: return (a <= b) ? 16'h0001 : 16'h0000;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_out = alu_f(bus.alu_operator, bus.alu_op1, bus.alu_op2);

  // Transaction model: architectural registers plus the one pending instruction.
  logic [15:0] rf [16];
  bit          m_busy;
  bit          m_age;     // 0: cycle after accept, 1: the writeback cycle
  logic [15:0] m_instr;
  logic [15:0] m_res;
  bit          m_write;
  bit          m_trap;
  logic [15:0] m_op1;
  logic [15:0] m_op2;

  function automatic logic [15:0] rd_rf(logic [3:0] a);
    return (a == 4'h0) ? 16'h0 : rf[a];
  endfunction

  function automatic bit exp_trap(logic [15:0] w);
`ifdef DIV_ZERO_TRAP_EN
    return ((w[15:12] == 4'h4) || (w[15:12] == 4'h5)) && (rd_rf(w[3:0]) == 16'h0);
`else
    return (w[15:12] == 4'hE) && 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_result(logic [15:0] w);
    if (w[15:12] == 4'h8) return {8'h00, w[7:0]};
    return alu_f(w[15:12], rd_rf(w[7:4]), rd_rf(w[3:0]));
  endfunction

  function automatic bit exp_write(logic [15:0] w);
    return (w[15:12] <= 4'h8) && !exp_trap(w);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_op1  <= 16'h0;
      m_op2  <= 16'h0;
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0;
    end else if (m_busy) begin
      if (!m_age) begin
        if (m_instr[15:12] > 4'h8) m_busy <= 1'b0;
        else m_age <= 1'b1;
      end else begin
        m_busy <= 1'b0;
        if (m_write && (m_instr[11:8] != 4'h0)) rf[m_instr[11:8]] <= m_res;
      end
    end else if (bus.instr_valid) begin
      m_busy  <= 1'b1;
      m_age   <= 1'b0;
      m_instr <= bus.instr;
      m_op1   <= rd_rf(bus.instr[7:4]);
      m_op2   <= rd_rf(bus.instr[3:0]);
      m_res   <= exp_result(bus.instr);
      m_write <= exp_write(bus.instr);
      m_trap  <= exp_trap(bus.instr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(!m_busy));
      chk("alu_operator", 32'(bus.alu_operator),
          32'((m_busy && !m_age) ? m_instr[15:12] : 4'hF));
      chk("alu_op1", 32'(bus.alu_op1), 32'(m_op1));
      chk("alu_op2", 32'(bus.alu_op2), 32'(m_op2));
      chk("wb_valid", 32'(bus.wb_valid), 32'(m_busy && m_age && m_write));
      if (m_busy && m_age && m_write) begin
        chk("wb_addr", 32'(bus.wb_addr), 32'(m_instr[11:8]));
        chk("wb_data", 32'(bus.wb_data), 32'(m_res));
      end
      chk("dbg_data", 32'(dbg_data), 32'(rd_rf(dbg_addr)));
`ifdef DIV_ZERO_TRAP_EN
      chk("div_zero", 32'(div_zero), 32'(m_busy && m_age && m_trap));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] w);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] w);
    issue(w);
    step();
    step();
  endtask

  logic [3:0] op;
  logic [5:0] ready_pat;
  int         accepted;

  initial begin
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0;
    dbg_addr        = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    chk("reset_ready", 32'(bus.instr_ready), 32'h1);
    chk("reset_operator", 32'(bus.alu_operator), 32'hF);
    chk("reset_op1", 32'(bus.alu_op1), 32'h0);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'h0);

    // LDI r1,0x12
    issue(16'h8112);
    chk("ldi_exec_no_wb", 32'(bus.wb_valid), 32'h0);
    step();
    chk("ldi_wb_valid", 32'(bus.wb_valid), 32'h1);
    chk("ldi_wb_addr", 32'(bus.wb_addr), 32'h1);
    chk("ldi_wb_data", 32'(bus.wb_data), 32'h0012);
    step();

    // ADD r3,r1,r2 with r1=5, r2=3
    run(16'h8105);
    run(16'h8203);
    issue(16'h0312);
    chk("add_operator", 32'(bus.alu_operator), 32'h0);
    step();
    chk("add_wb_data", 32'(bus.wb_data), 32'h0008);
    step();
    dbg_addr = 4'h3;
    #1;
    chk("add_dbg_r3", 32'(dbg_data), 32'h0008);

    // SUB r4,r1,r2 with r1=0, r2=1 wraps
    run(16'h8100);
    run(16'h8201);
    issue(16'h1412);
    step();
    chk("sub_wrap", 32'(bus.wb_data), 32'hFFFF);
    step();

    // instr_valid held for six cycles
    ready_pat       = 6'b001001;
    accepted        = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h8611;
    for (int c = 0; c < 6; c++) begin
      chk("hold_ready_pattern", 32'(bus.instr_ready), 32'(ready_pat[c]));
      if (bus.instr_ready) accepted++;
      step();
    end
    bus.instr_valid = 1'b0;
    chk("hold_accept_count", 32'(accepted), 32'd2);

    // NOP retires in two cycles; LDI r0 pulses but r0 stays zero
    issue(16'hF000);
    chk("nop_no_wb", 32'(bus.wb_valid), 32'h0);
    step();
    chk("nop_idle", 32'(bus.instr_ready), 32'h1);
    issue(16'h80FF);
    step();
    chk("ldi_r0_wb_valid", 32'(bus.wb_valid), 32'h1);
    chk("ldi_r0_wb_addr", 32'(bus.wb_addr), 32'h0);
    step();
    dbg_addr = 4'h0;
    #1;
    chk("r0_reads_zero", 32'(dbg_data), 32'h0);

    // Reset during EXEC abandons the instruction
    issue(16'h0312);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst_ready", 32'(bus.instr_ready), 32'h1);
    chk("rst_no_wb", 32'(bus.wb_valid), 32'h0);
    dbg_addr = 4'h3;
    #1;
    chk("rst_r3_clear", 32'(dbg_data), 32'h0);
    dbg_addr = 4'h6;
    #1;
    chk("rst_r6_clear", 32'(dbg_data), 32'h0);

`ifdef DIV_ZERO_TRAP_EN
    // DIV r5,r1,r0 traps
    run(16'h8107);
    issue(16'h4510);
    step();
    chk("div0_pulse", 32'(div_zero), 32'h1);
    chk("div0_no_wb", 32'(bus.wb_valid), 32'h0);
    step();
    chk("div0_pulse_ends", 32'(div_zero), 32'h0);
    dbg_addr = 4'h5;
    #1;
    chk("div0_r5_unwritten", 32'(dbg_data), 32'h0);
`endif

    for (int c = 0; c < 800; c++) begin
      op              = ($urandom_range(0, 3) == 0) ? 4'h8 : 4'($urandom_range(0, 15));
      bus.instr_valid = ($urandom_range(0, 2) != 0);
      bus.instr       = {op, 12'($urandom)};
      dbg_addr        = 4'($urandom);
      rst             = ($urandom_range(0, 79) != 0);
      step();
    end

    bus.instr_valid = 1'b0;
    rst             = 1'b1;
    repeat (3) step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
